// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential shift-and-add-3 (double-dabble) binary to packed BCD converter.
// Converts one input bit per clock. The result is held on bcd_out between
// conversions. The output feeds a four-digit seven-segment driver:
// bcd_out[7:0] goes to byte0 (digits 0,1) and bcd_out[15:8] to byte1
// (digits 2,3).
//
// Handshake: a conversion starts on any rising clk edge where start=1 and the
// converter is idle. bin_in is captured on that edge only. busy is high from
// the accepting edge until the final iteration edge. done pulses for exactly
// one cycle on that final edge, and bcd_out/ovf update on the same edge.
// A start seen while busy is ignored.
//
// Parameters:
//   BIN_W   - width of the binary input (default 14, covers 0..16383)
//   DIGITS  - number of BCD digits on bcd_out (default 4)
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   start    in   conversion request
//   bin_in   in   [BIN_W-1:0] binary value, captured on the accepting edge
//   busy     out  conversion in progress
//   done     out  one-cycle pulse, bcd_out/ovf valid from this cycle
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   ovf      out  result exceeded 10^DIGITS-1 (saturation build only)
//
// Build option:
//   BIN2BCD_SAT_EN - when defined, out-of-range values saturate bcd_out to
//                    all 9s and set ovf. When undefined, bcd_out carries the
//                    value mod 10^DIGITS and ovf is tied low.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    // The saturating build needs one extra scratch digit to see whether the
    // value spilled past DIGITS digits. Without saturation the digits above
    // DIGITS never influence the lower ones, so the scratch stays narrow.
`ifdef BIN2BCD_SAT_EN
    localparam int SD = DIGITS + 1;
`else
    localparam int SD = DIGITS;
`endif
    localparam int SW = 4 * SD;
    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic [SW-1:0]       scr;
    logic [SW-1:0]       scr_adj;
    logic [SW-1:0]       scr_nx;
    logic [BIN_W-1:0]    bin_sr;
    logic [BIN_W-1:0]    bin_nx;
    logic [SW+BIN_W-1:0] shifted;
    logic [CW-1:0]       cnt;
    logic                accept;
    logic                last;

    assign accept = (state == IDLE) && start;
    // The iteration that takes cnt from 1 to 0 is the final one.
    assign last   = (state == SHIFT) && (cnt == CW'(1));
    assign busy   = (state == SHIFT);

    // One double-dabble iteration: add 3 to every digit >= 5, then shift the
    // combined {scratch, binary} register left by one.
    always_comb begin
        scr_adj = scr;
        for (int d = 0; d < SD; d++) begin
            if (scr[4*d +: 4] >= 4'd5) begin
                scr_adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
            end
        end
        shifted = {scr_adj, bin_sr} << 1;
        scr_nx  = shifted[SW+BIN_W-1:BIN_W];
        bin_nx  = shifted[BIN_W-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. A start in the done cycle is accepted because the
    // final edge has already returned the FSM to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef BIN2BCD_SAT_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr     <= '0;
            bin_sr  <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            bcd_out <= '0;
`ifdef BIN2BCD_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done <= last;

            if (accept) begin
                bin_sr <= bin_in;
                scr    <= '0;
                cnt    <= CW'(BIN_W);
            end else if (state == SHIFT) begin
                scr    <= scr_nx;
                bin_sr <= bin_nx;
                cnt    <= cnt - 1'b1;
            end

            // bcd_out and ovf move only on the done edge, so the display
            // never sees intermediate scratch values.
            if (last) begin
`ifdef BIN2BCD_SAT_EN
                if (scr_nx[SW-1:OW] != '0) begin
                    bcd_out <= {DIGITS{4'h9}};
                    ovf_q   <= 1'b1;
                end else begin
                    bcd_out <= scr_nx[OW-1:0];
                    ovf_q   <= 1'b0;
                end
`else
                bcd_out <= scr_nx[OW-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Directed bench for bin2bcd_seq (BIN_W=14, DIGITS=4). Inputs are driven and
// outputs sampled 1 time unit after each rising clk edge. Expected values are
// hand-written constants for the directed steps and a divide/modulo decimal
// model for the sweep.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(
        .BIN_W  (14),
        .DIGITS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent decimal model: digits by repeated divide/modulo.
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        if (SAT && v > 9999) return 16'h9999;
        x = v % 10000;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int v);
        return SAT && (v > 9999);
    endfunction

    // Called right after the accepting edge. Returns the number of edges from
    // the accepting edge to the edge that raised done (-1 on timeout) and
    // the number of sampled cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cnt);
        busy_cnt = int'(busy);
        edges    = 0;
        do begin
            tick();
            edges++;
            busy_cnt += int'(busy);
        end while (!done && edges < 40);
        if (!done) edges = -1;
    endtask

    task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                           input string tag);
        int e;
        int b;
        start  = 1'b1;
        bin_in = 14'(v);
        tick();
        start  = 1'b0;
        bin_in = 14'($urandom_range(0, 16383));
        wait_done(e, b);
        check({tag, " latency"}, e, 14);
        check({tag, " busy_cycles"}, b, 14);
        check({tag, " bcd"}, bcd_out, exp_bcd);
        check({tag, " ovf"}, ovf, exp_ovf);
        tick();
        check({tag, " done_width"}, done, 1'b0);
        check({tag, " bcd_hold"}, bcd_out, exp_bcd);
    endtask

    initial begin
        int e;
        int b;
        int ndone;
        int done_edge;

        // ---------------- reset ----------------
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset bcd", bcd_out, 16'h0000);
        check("reset ovf", ovf, 1'b0);
        rst = 1'b1;
        tick();
        check("idle done", done, 1'b0);

        // ---------------- 1234 ----------------
        convert(1234, 16'h1234, 1'b0, "t1_1234");

        // ---------------- back-to-back 0 then 9999, start held ----------------
        start  = 1'b1;
        bin_in = 14'd0;
        tick();
        bin_in = 14'd9999;        // held during SHIFT, taken at the next accept
        wait_done(e, b);
        check("b2b first latency", e, 14);
        check("b2b first bcd", bcd_out, 16'h0000);
        tick();                   // start still high in the done cycle: accepted here
        check("b2b restart busy", busy, 1'b1);
        check("b2b restart done_low", done, 1'b0);
        check("b2b restart bcd_hold", bcd_out, 16'h0000);
        wait_done(e, b);
        start = 1'b0;
        // second done is 1 + 14 = 15 edges after the first
        check("b2b second latency", e, 14);
        check("b2b second bcd", bcd_out, 16'h9999);
        check("b2b second ovf", ovf, 1'b0);
        tick();
        check("b2b done_width", done, 1'b0);

        // ---------------- out of range 12345 ----------------
        convert(12345, SAT ? 16'h9999 : 16'h2345, SAT, "t3_12345");
        convert(42, 16'h0042, 1'b0, "t3_ovf_clear");

        // ---------------- starts while busy are ignored ----------------
        start  = 1'b1;
        bin_in = 14'd4321;
        tick();
        start     = 1'b0;
        bin_in    = 14'd8888;
        ndone     = 0;
        done_edge = -1;
        for (int k = 1; k <= 30; k++) begin
            start = (k == 3 || k == 10);
            tick();
            if (done) begin
                ndone++;
                done_edge = k;
            end
        end
        start = 1'b0;
        check("busy_start done_count", ndone, 1);
        check("busy_start done_edge", done_edge, 14);
        check("busy_start bcd", bcd_out, 16'h4321);

        // ---------------- reset mid-conversion ----------------
        convert(5678, 16'h5678, 1'b0, "t5_5678");
        start  = 1'b1;
        bin_in = 14'd1111;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b0;
        #1;
        check("midreset bcd", bcd_out, 16'h0000);
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        tick();
        tick();
        rst   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        check("midreset no_done", ndone, 0);
        check("midreset bcd_after", bcd_out, 16'h0000);
        convert(42, 16'h0042, 1'b0, "t5_42");

        // ---------------- boundaries ----------------
        convert(0, 16'h0000, 1'b0, "bnd_0");
        convert(9999, 16'h9999, 1'b0, "bnd_9999");
        convert(10000, SAT ? 16'h9999 : 16'h0000, SAT, "bnd_10000");
        convert(16383, SAT ? 16'h9999 : 16'h6383, SAT, "bnd_16383");
        convert(1, 16'h0001, 1'b0, "bnd_1");

        // ---------------- sampled sweep against the decimal model ----------------
        for (int v = 0; v < 100; v++)
            convert(v, model_bcd(v), model_ovf(v), $sformatf("sweep_%0d", v));
        for (int v = 100; v < 9990; v += 37)
            convert(v, model_bcd(v), model_ovf(v), $sformatf("sweep_%0d", v));
        for (int v = 9990; v < 10000; v++)
            convert(v, model_bcd(v), model_ovf(v), $sformatf("sweep_%0d", v));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
